button_debounce_arbiter: RTL

//  Debounces N_BTN raw push-buttons using ONE shared debounce timer instead of one timer per button.
//  A round-robin scheduler grants the timer to one button at a time.

---
 rtl/btn_ctrl_pkg.sv | 5 +
 rtl/btn_sync.sv | 17 +
 rtl/button_debounce_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/btn_ctrl_pkg.sv
// btn_ctrl_pkg: shared FSM state type and synchroniser depth for the button debounce arbiter.
package btn_ctrl_pkg;
  typedef enum logic [1:0] {SCAN, QUALIFY, COMMIT} state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/btn_sync.sv
// btn_sync: parameterised-width multi-flop synchroniser for asynchronous inputs, reset to 0.
module btn_sync
  import btn_ctrl_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [SYNC_STAGES-1:0][W-1:0] sr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else sr_q <= {sr_q[SYNC_STAGES-2:0], d_i};
  assign q_o = sr_q[SYNC_STAGES-1];
endmodule

// File: rtl/button_debounce_arbiter.sv
// button_debounce_arbiter: debounces N_BTN buttons with one round-robin shared timer.
// Optional long-press detection is built when BTN_LONG_PRESS_EN is defined.
module button_debounce_arbiter
  import btn_ctrl_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int LONG_CYCLES     = 500000,
  localparam int IW = $clog2(N_BTN),
  localparam int CW = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] stable_o,
  output logic [N_BTN-1:0] press_p,
  output logic [N_BTN-1:0] release_p,
  output logic [N_BTN-1:0] long_p,
  output logic             busy,
  output logic [IW-1:0]    grant_idx
);
  if (N_BTN < 2 || N_BTN > 16 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_param
    $error("button_debounce_arbiter: parameter out of range");
  end
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_BTN-1:0] sync, mismatch, hit, stable_q, press_q, release_q;
  logic [IW:0] pick;
  btn_sync #(.W(N_BTN)) u_sync (.clk(clk), .rst_n(rst_n), .d_i(button), .q_o(sync));
  assign mismatch = sync ^ stable_q;
  // Returns {found, index} of the first requester at or after p, wrapping around.
  function automatic logic [IW:0] rr_pick(input logic [N_BTN-1:0] req, input logic [IW-1:0] p);
    int j;
    rr_pick = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      j = (int'(p) + k) % N_BTN;
      if (req[j]) rr_pick = {1'b1, IW'(j)};
    end
  endfunction
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(N_BTN - 1)) ? '0 : i + 1'b1;
  endfunction
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pick    = rr_pick(mismatch, ptr_q);
    case (state_q)
      SCAN: if (pick[IW]) begin
        state_d = QUALIFY;
        idx_d   = pick[IW-1:0];
        cnt_d   = '0;
      end
      QUALIFY: if (!mismatch[idx_q]) begin
        state_d = SCAN;
        ptr_d   = nxt(idx_q);
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) state_d = COMMIT;
      else cnt_d = cnt_q + 1'b1;
      COMMIT: begin
        state_d = SCAN;
        ptr_d   = nxt(idx_q);
      end
      default: state_d = SCAN;
    endcase
  end
  assign hit = (state_q == COMMIT) ? N_BTN'(1) << idx_q : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= SCAN;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_q ^ hit;
      press_q   <= hit & ~stable_q;
      release_q <= hit & stable_q;
    end
  assign stable_o  = stable_q;
  assign press_p   = press_q;
  assign release_p = release_q;
  assign busy      = state_q != SCAN;
  assign grant_idx = idx_q;
`ifdef BTN_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES);
  logic [LW-1:0] hold_cnt_q;
  logic [IW-1:0] hold_idx_q;
  logic hold_act_q;
  logic [N_BTN-1:0] long_q;
  logic rose;
  assign rose = |(hit & ~stable_q);
  // Tracks only the most recent press; another press restarts it on that button.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_cnt_q <= '0;
      hold_idx_q <= '0;
      hold_act_q <= 1'b0;
      long_q     <= '0;
    end else begin
      long_q <= '0;
      if (rose) begin
        hold_act_q <= 1'b1;
        hold_idx_q <= idx_q;
        hold_cnt_q <= '0;
      end else if (hold_act_q) begin
        if (!stable_q[hold_idx_q] || hit[hold_idx_q]) hold_act_q <= 1'b0;
        else if (hold_cnt_q == LW'(LONG_CYCLES - 1)) begin
          long_q     <= N_BTN'(1) << hold_idx_q;
          hold_act_q <= 1'b0;
        end else hold_cnt_q <= hold_cnt_q + 1'b1;
      end
    end
  assign long_p = long_q;
`else
  assign long_p = '0;
`endif
endmodule
